// File: rtl/msu_pkg.sv
// Shared types and constants for the MSU-1 EXT sector-bus arbiter.
// The optional ack-wait timeout is enabled with the MSU_EXT_ARB_TIMEOUT_EN macro.
package msu_pkg;

  localparam int MSU_SECTOR_W = 22;

  localparam logic MSU_REQ_DATA  = 1'b0;
  localparam logic MSU_REQ_AUDIO = 1'b1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    XFER     = 2'd2,
    GAP      = 2'd3
  } msu_arb_state_t;

  // Urgent audio wins outright; a tie goes to whoever was not served last.
  function automatic logic msu_pick(input logic audio_req, input logic data_req,
                                    input logic audio_urgent, input logic last_grant);
    if (audio_urgent && audio_req) return MSU_REQ_AUDIO;
    if (audio_req && data_req)     return ~last_grant;
    return audio_req ? MSU_REQ_AUDIO : MSU_REQ_DATA;
  endfunction

endpackage

// File: rtl/msu_ack_timer.sv
// Ack-wait counter: cleared by start, counts while run, flags expire on the last allowed cycle.
// Only instantiated when MSU_EXT_ARB_TIMEOUT_EN is defined.
module msu_ack_timer #(
  parameter int           W     = 24,
  parameter logic [W-1:0] LIMIT = {W{1'b1}}
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic run,
  output logic expire
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      count <= '0;
    else if (start) count <= '0;
    else if (run)   count <= count + 1'b1;
  end

  assign expire = run && (count == LIMIT - 1'b1);

endmodule

// File: rtl/msu_ext_arbiter.sv
// Arbitrates whole-sector EXT bus transactions between the MSU data reader and audio sequencer.
// Define MSU_EXT_ARB_TIMEOUT_EN to abandon transactions whose ack never arrives.
module msu_ext_arbiter
  import msu_pkg::*;
#(
  parameter int          SECTOR_W       = MSU_SECTOR_W,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd8_000_000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                audio_req,
  input  logic [SECTOR_W-1:0] audio_sector,
  input  logic                audio_jump,
  input  logic                audio_urgent,
  input  logic                data_req,
  input  logic [SECTOR_W-1:0] data_sector,
  input  logic                data_jump,
  input  logic                ext_ack,
  input  logic                ext_wr,
  output logic                ext_req,
  output logic [SECTOR_W-1:0] ext_sector,
  output logic                ext_jump_sector,
  output logic                ext_sel,
  output logic                audio_ack,
  output logic                audio_wr,
  output logic                data_ack,
  output logic                data_wr,
  output logic                audio_timeout,
  output logic                data_timeout
);

  msu_arb_state_t state, state_next;
  logic grant, last_grant;
  logic pick, pick_grant, expire, timeout_fire, active;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_next   = state;
    pick         = 1'b0;
    pick_grant   = last_grant;
    timeout_fire = 1'b0;
    case (state)
      IDLE: if (audio_req || data_req) begin
        pick       = 1'b1;
        pick_grant = msu_pick(audio_req, data_req, audio_urgent, last_grant);
        state_next = WAIT_ACK;
      end
      WAIT_ACK: if (ext_ack) begin
        state_next = XFER;
      end else if (expire) begin
        timeout_fire = 1'b1;
        state_next   = GAP;
      end
      XFER:    if (!ext_ack) state_next = GAP;
      GAP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: last_grant resets to AUDIO so the very first tie goes to DATA.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant           <= MSU_REQ_DATA;
      last_grant      <= MSU_REQ_AUDIO;
      ext_req         <= 1'b0;
      ext_sector      <= '0;
      ext_jump_sector <= 1'b0;
    end else if (pick) begin
      grant           <= pick_grant;
      last_grant      <= pick_grant;
      ext_req         <= 1'b1;
      ext_sector      <= pick_grant ? audio_sector : data_sector;
      ext_jump_sector <= pick_grant ? audio_jump : data_jump;
    end else if (state == WAIT_ACK && state_next != WAIT_ACK) begin
      ext_req <= 1'b0;
    end
  end

  assign ext_sel = grant;

  // ack/wr reach only the granted requester, and only while its transaction is live.
  assign active    = (state == WAIT_ACK) || (state == XFER);
  assign audio_ack = ext_ack & active & grant;
  assign audio_wr  = ext_wr  & active & grant;
  assign data_ack  = ext_ack & active & ~grant;
  assign data_wr   = ext_wr  & active & ~grant;

`ifdef MSU_EXT_ARB_TIMEOUT_EN
  msu_ack_timer #(
    .W     (24),
    .LIMIT (TIMEOUT_CYCLES)
  ) u_ack_timer (
    .clk    (clk),
    .reset  (reset),
    .start  (pick),
    .run    (state == WAIT_ACK),
    .expire (expire)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      audio_timeout <= 1'b0;
      data_timeout  <= 1'b0;
    end else begin
      audio_timeout <= timeout_fire & grant;
      data_timeout  <= timeout_fire & ~grant;
    end
  end
`else
  assign expire        = 1'b0;
  assign audio_timeout = 1'b0;
  assign data_timeout  = 1'b0;
`endif

endmodule
